// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the injector and the router.
// Contents: flit width, flit type codes, flit and command field offsets,
// op encodings, packed views of the command word and the flit, the injector
// FSM state type, and a flit builder helper.
package noc_pkg;

   localparam int unsigned FlitW = 16;

   // Processor command word: [10:9] op, [8:6] body count, [5:2] seed, [1:0] dst.
   localparam int unsigned CfgW      = 11;
   localparam int unsigned CfgOpLsb  = 9;
   localparam int unsigned CfgNLsb   = 6;
   localparam int unsigned CfgSeedLsb = 2;
   localparam int unsigned CfgDstLsb = 0;

   localparam logic [1:0] OpIdle = 2'b00;
   localparam logic [1:0] OpSend = 2'b01;

   // Flit: [15:14] type, [13:12] src, [11:10] dst, [9:0] data.
   localparam int unsigned FlitTypeLsb = 14;
   localparam int unsigned FlitSrcLsb  = 12;
   localparam int unsigned FlitDstLsb  = 10;
   localparam int unsigned FlitDataW   = 10;

   typedef enum logic [1:0] {
      FlitNone = 2'b00,
      FlitHead = 2'b01,
      FlitBody = 2'b10,
      FlitTail = 2'b11
   } flit_type_e;

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] n;
      logic [3:0] seed;
      logic [1:0] dst;
   } cmd_t;

   typedef struct packed {
      flit_type_e      ftype;
      logic [1:0]      src;
      logic [1:0]      dst;
      logic [FlitDataW-1:0] data;
   } flit_t;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StHead = 2'b01,
      StBody = 2'b10,
      StTail = 2'b11
   } inj_state_e;

   function automatic flit_t make_flit(flit_type_e ftype, logic [1:0] src, logic [1:0] dst,
                                       logic [FlitDataW-1:0] data);
      flit_t f;
      f.ftype = ftype;
      f.src   = src;
      f.dst   = dst;
      f.data  = data;
      return f;
   endfunction

endpackage

// File: rtl/noc_cmd_capture.sv
// Command edge detector and one-entry pending slot for the NoC injector.
// Ports:
//   clock, reset         - clock, asynchronous active-low reset
//   configure[10:0]      - processor command word
//   direct_ok            - injector FSM is idle and can take a command now
//   pend_pop             - injector is consuming the pending command this cycle
//   direct_cap           - a command is being handed straight to the FSM this cycle
//   pend_valid/pend_word - pending slot contents
//   pend_valid_next      - pending slot occupancy after this edge
//   cmd_error            - one-cycle pulse when a send to this node is dropped
module noc_cmd_capture
   import noc_pkg::*;
#(
   parameter int unsigned NODE_ID = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [10:0] configure,
   input  logic        direct_ok,
   input  logic        pend_pop,
   output logic        direct_cap,
   output logic        pend_valid,
   output logic [10:0] pend_word,
   output logic        pend_valid_next,
   output logic        cmd_error
);

   localparam logic [1:0] SelfId = 2'(NODE_ID);

   logic [10:0] hist_q;
   logic        pend_valid_q, pend_valid_d;
   logic [10:0] pend_word_q, pend_word_d;
   logic        err_q, err_d;

   cmd_t cur, prev;
   logic detect, self_dst, accepted, pend_fill;

   assign cur  = cmd_t'(configure);
   assign prev = cmd_t'(hist_q);

   // New command on entry into op=send, or on any word change while staying in send.
   assign detect   = (cur.op == OpSend) && ((prev.op != OpSend) || (configure != hist_q));
   assign self_dst = (cur.dst == SelfId);
   assign accepted = detect && !self_dst;

   always_comb begin
      direct_cap   = accepted && direct_ok;
      // A full slot keeps its command; the new one is dropped.
      pend_fill    = accepted && !direct_ok && !pend_valid_q;
      pend_valid_d = pend_fill || (pend_valid_q && !pend_pop);
      pend_word_d  = pend_fill ? configure : pend_word_q;
      err_d        = detect && self_dst;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_word_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         hist_q       <= configure;
         pend_valid_q <= pend_valid_d;
         pend_word_q  <= pend_word_d;
         err_q        <= err_d;
      end
   end

   assign pend_valid      = pend_valid_q;
   assign pend_word       = pend_word_q;
   assign pend_valid_next = pend_valid_d;
   assign cmd_error       = err_q;

endmodule

// File: rtl/noc_injector.sv
// NoC packet injector: turns processor send commands into head/body/tail flits
// for the local router port.
// Ports:
//   clock, reset     - clock, asynchronous active-low reset
//   configure[10:0]  - command word {op, body count, seed, dst}
//   flit_out         - flit {type, src, dst, data}
//   flit_valid       - flit_out is valid
//   flit_ready       - router accepts flit_out this cycle
//   processor_ready  - idle with no pending command
//   cmd_error        - pulse when a send to this node is dropped
module noc_injector
   import noc_pkg::*;
#(
   parameter int unsigned NODE_ID = 0,
   parameter int unsigned FLIT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [10:0]       configure,
   output logic [FLIT_W-1:0] flit_out,
   output logic              flit_valid,
   input  logic              flit_ready,
   output logic              processor_ready,
   output logic              cmd_error
);

   localparam logic [1:0] SrcId = 2'(NODE_ID);

   inj_state_e state_q, state_d;
   logic [2:0] n_q, n_d;
   logic [3:0] seed_q, seed_d;
   logic [1:0] dst_q, dst_d;
   logic [2:0] cnt_q, cnt_d;
   logic       rdy_q, rdy_d;

   logic        direct_cap, pend_valid, pend_valid_next, pend_pop;
   logic [10:0] pend_word, load_word;
   logic        load, fire;
   logic [3:0]  body_nib;
   flit_t       flit;

   noc_cmd_capture #(
      .NODE_ID(NODE_ID)
   ) u_capture (
      .clock          (clock),
      .reset          (reset),
      .configure      (configure),
      .direct_ok      (state_q == StIdle),
      .pend_pop       (pend_pop),
      .direct_cap     (direct_cap),
      .pend_valid     (pend_valid),
      .pend_word      (pend_word),
      .pend_valid_next(pend_valid_next),
      .cmd_error      (cmd_error)
   );

   assign fire = flit_valid && flit_ready;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         n_q     <= '0;
         seed_q  <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         seed_q  <= seed_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      seed_d    = seed_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      pend_pop  = 1'b0;
      load      = 1'b0;
      load_word = configure;

      unique case (state_q)
         StIdle: begin
            if (direct_cap) begin
               load    = 1'b1;
               state_d = StHead;
            end else if (pend_valid) begin
               // Slot filled on the same edge the previous tail left for idle.
               pend_pop  = 1'b1;
               load      = 1'b1;
               load_word = pend_word;
               state_d   = StHead;
            end
         end
         StHead: begin
            if (fire) begin
               cnt_d   = '0;
               state_d = (n_q == 3'd0) ? StTail : StBody;
            end
         end
         StBody: begin
            if (fire) begin
               if (cnt_q == n_q - 3'd1) begin
                  state_d = StTail;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         StTail: begin
            if (fire) begin
               if (pend_valid) begin
                  pend_pop  = 1'b1;
                  load      = 1'b1;
                  load_word = pend_word;
                  state_d   = StHead;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         {n_d, seed_d, dst_d} = load_word[CfgOpLsb-1:0];
         cnt_d                = '0;
      end

      rdy_d = (state_d == StIdle) && !pend_valid_next;
   end

   // Output logic: flits are decoded from held state, so they stay stable under backpressure.
   always_comb begin
      flit       = '0;
      flit_valid = 1'b0;
      body_nib   = seed_q + {1'b0, cnt_q};
      unique case (state_q)
         StIdle: begin
            flit       = '0;
            flit_valid = 1'b0;
         end
         StHead: begin
            flit       = make_flit(FlitHead, SrcId, dst_q, {3'b000, n_q, seed_q});
            flit_valid = 1'b1;
         end
         StBody: begin
            flit       = make_flit(FlitBody, SrcId, dst_q, {6'b000000, body_nib});
            flit_valid = 1'b1;
         end
         StTail: begin
            flit       = make_flit(FlitTail, SrcId, dst_q, '0);
            flit_valid = 1'b1;
         end
         default: begin
            flit       = '0;
            flit_valid = 1'b0;
         end
      endcase
   end

   assign flit_out        = flit;
   assign processor_ready = rdy_q;

endmodule

// File: tb/tb_noc_injector.sv
// Scoreboard bench for noc_injector: directed commands push hand-computed flits,
// a negedge monitor pops and compares every accepted flit.
module tb_noc_injector;

   logic        clock = 1'b0;
   logic        reset;
   logic [10:0] cfg0, cfg1;
   logic [15:0] fo0, fo1;
   logic        fv0, fv1, fr0, fr1, pr0, pr1, ce0, ce1;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [15:0] sb[$];
   int          acc[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   noc_injector #(
      .NODE_ID(0),
      .FLIT_W (16)
   ) dut0 (
      .clock          (clock),
      .reset          (reset),
      .configure      (cfg0),
      .flit_out       (fo0),
      .flit_valid     (fv0),
      .flit_ready     (fr0),
      .processor_ready(pr0),
      .cmd_error      (ce0)
   );

   noc_injector #(
      .NODE_ID(1),
      .FLIT_W (16)
   ) dut1 (
      .clock          (clock),
      .reset          (reset),
      .configure      (cfg1),
      .flit_out       (fo1),
      .flit_valid     (fv1),
      .flit_ready     (fr1),
      .processor_ready(pr1),
      .cmd_error      (ce1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every flit the router accepts must be the next expected one.
   always @(negedge clock) begin
      if (reset && fv0 && fr0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_flit: got %h, expected none", fo0);
         end else begin
            chk("flit", 32'(fo0), 32'(sb.pop_front()));
         end
         acc.push_back(cyc);
      end
   end

   // Wait for scoreboard empty and processor_ready, noting any early ready.
   task automatic drain(input string name, input int budget, output bit early);
      int k;
      k     = 0;
      early = 1'b0;
      while (!(sb.size() == 0 && pr0) && k < budget) begin
         @(posedge clock);
         #1;
         if (pr0 && sb.size() != 0) early = 1'b1;
         k++;
      end
      chk({name, "_drained"}, 32'(sb.size() == 0 && pr0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit early;
      int k, pulses;
      bit seen_v, seen_nr;

      reset = 1'b0;
      cfg0  = '0;
      cfg1  = '0;
      fr0   = 1'b1;
      fr1   = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", 32'(fv0), 32'd0);
      chk("rst_flit", 32'(fo0), 32'h0);
      chk("rst_ready", 32'(pr0), 32'd1);
      chk("rst_err", 32'(ce0), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Zero-body packet, word held 50 cycles: exactly one packet.
      sb.push_back(16'h4401);
      sb.push_back(16'hC400);
      cfg0 = 11'b01000000101;
      @(posedge clock);
      #1;
      chk("head_latency", 32'(fv0), 32'd1);
      chk("head_word", 32'(fo0), 32'h4401);
      chk("ready_low", 32'(pr0), 32'd0);
      repeat (48) @(posedge clock);
      #1;
      chk("single_pkt_done", 32'(sb.size()), 32'd0);
      chk("idle_valid", 32'(fv0), 32'd0);
      chk("idle_ready", 32'(pr0), 32'd1);
      cfg0 = '0;

      // Three bodies with seed wrap.
      acc.delete();
      sb.push_back(16'h483E);
      sb.push_back(16'h880E);
      sb.push_back(16'h880F);
      sb.push_back(16'h8800);
      sb.push_back(16'hC800);
      @(posedge clock);
      #1;
      cfg0 = {2'b01, 3'd3, 4'hE, 2'd2};
      drain("wrap", 40, early);
      chk("wrap_count", 32'(acc.size()), 32'd5);
      cfg0 = '0;

      // Backpressure on the head for 4 cycles.
      acc.delete();
      fr0 = 1'b0;
      sb.push_back(16'h4C15);
      sb.push_back(16'h8C05);
      sb.push_back(16'hCC00);
      @(posedge clock);
      #1;
      cfg0 = {2'b01, 3'd1, 4'd5, 2'd3};
      @(posedge clock);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("stall_valid", 32'(fv0), 32'd1);
         chk("stall_word", 32'(fo0), 32'h4C15);
      end
      @(posedge clock);
      #1;
      fr0 = 1'b1;
      drain("stall", 40, early);
      chk("stall_count", 32'(acc.size()), 32'd3);
      cfg0 = '0;

      // Pending command follows back-to-back; a third command is dropped.
      @(posedge clock);
      #1;
      acc.delete();
      sb.push_back(16'h4421);
      sb.push_back(16'h8401);
      sb.push_back(16'h8402);
      sb.push_back(16'hC400);
      sb.push_back(16'h4807);
      sb.push_back(16'hC800);
      cfg0 = {2'b01, 3'd2, 4'd1, 2'd1};
      @(posedge clock);
      #1;
      cfg0 = {2'b01, 3'd0, 4'd7, 2'd2};
      @(posedge clock);
      #1;
      cfg0 = {2'b01, 3'd1, 4'd3, 2'd3};
      drain("b2b", 60, early);
      chk("b2b_early_ready", 32'(early), 32'd0);
      chk("b2b_count", 32'(acc.size()), 32'd6);
      chk("b2b_gap", (acc.size() >= 5) ? 32'(acc[4] - acc[3]) : 32'hFFFF_FFFF, 32'd1);
      repeat (20) @(posedge clock);
      #1;
      chk("third_dropped", 32'(acc.size()), 32'd6);
      cfg0 = '0;

      // Send to self on node 1: error pulse only.
      pulses  = 0;
      seen_v  = 1'b0;
      seen_nr = 1'b0;
      @(posedge clock);
      #1;
      cfg1 = {2'b01, 3'd2, 4'd4, 2'd1};
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (ce1) pulses++;
         if (fv1) seen_v = 1'b1;
         if (!pr1) seen_nr = 1'b1;
      end
      chk("self_err_pulses", 32'(pulses), 32'd1);
      chk("self_no_flit", 32'(seen_v), 32'd0);
      chk("self_ready_kept", 32'(seen_nr), 32'd0);
      cfg1 = '0;

      // Reset during a body flit, then a full resend of the held word.
      acc.delete();
      sb.push_back(16'h4C42);
      @(posedge clock);
      #1;
      cfg0 = {2'b01, 3'd4, 4'd2, 2'd3};
      k    = 0;
      do begin
         @(posedge clock);
         #1;
         k++;
      end while (!(fv0 && fo0[15:14] == 2'b10) && k < 20);
      chk("body_reached", 32'(fv0 && fo0[15:14] == 2'b10), 32'd1);
      fr0 = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(fv0), 32'd0);
      chk("rst_mid_flit", 32'(fo0), 32'h0);
      chk("rst_mid_sb", 32'(sb.size()), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      fr0   = 1'b1;
      sb.push_back(16'h4C42);
      sb.push_back(16'h8C02);
      sb.push_back(16'h8C03);
      sb.push_back(16'h8C04);
      sb.push_back(16'h8C05);
      sb.push_back(16'hCC00);
      drain("resend", 60, early);
      chk("resend_count", 32'(acc.size()), 32'd7);
      cfg0 = '0;
      repeat (5) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
